ftdi_fifo_arbiter: RTL and testbench

- Sequences the FT232H asynchronous 245-FIFO port: RXF#/TXE# status, RD#/WR# strobes, and the shared bidirectional ADBUS with its tristate enable.
- Arbitrates the single bus between the host→FPGA read path and the FPGA→host write path.
- Exposes both paths to the laser link logic as byte streams with valid/ready handshakes.
- Sits between the top-level pin mapping (ADBUS, ACBUS[3:0]) and the laser TX/RX datapath.

---
 rtl/ftdi_pkg.sv | 32 +++
 rtl/sync2.sv | 26 ++
 rtl/ftdi_fifo_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ftdi_fifo_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FT232H 245-FIFO arbiter.
package ftdi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LOW,
    WR_SETUP,
    WR_LOW,
    WR_HOLD,
    RECOVER
  } ftdi_state_t;

  typedef enum logic {
    GRANT_READ,
    GRANT_WRITE
  } grant_t;

  localparam int SYNC_STAGES = 2;

  // Largest of the phase lengths; sizes the shared phase-cycle counter.
  function automatic int max_cyc(input int a, input int b, input int c,
                                 input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/sync2.sv
// Multi-flop synchronizer for one asynchronous FTDI status line.
module sync2
  import ftdi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/ftdi_fifo_arbiter.sv
// Sequences the FT232H asynchronous 245-FIFO port and arbitrates the shared
// ADBUS between the host-to-FPGA read path and the FPGA-to-host write path.
module ftdi_fifo_arbiter
  import ftdi_pkg::*;
#(
  parameter int RD_LOW_CYC   = 3,
  parameter int WR_SETUP_CYC = 1,
  parameter int WR_LOW_CYC   = 3,
  parameter int WR_HOLD_CYC  = 1,
  parameter int RECOV_CYC    = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             rxf_n,
  input  logic             txe_n,
  input  logic [7:0]       adbus_in,
  output logic [7:0]       adbus_out,
  output logic             adbus_tri,
  output logic             ftdi_rd_n,
  output logic             ftdi_wr_n,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             busy,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] tx_count
);

  localparam int MAX_CYC = max_cyc(RD_LOW_CYC, WR_SETUP_CYC, WR_LOW_CYC,
                                   WR_HOLD_CYC, RECOV_CYC);
  localparam int CYC_W   = $clog2(MAX_CYC) + 1;

  ftdi_state_t      state;
  grant_t           last_grant;
  logic [CYC_W-1:0] cyc;
  logic             rxf_s;
  logic             txe_s;
  logic             rd_req;
  logic             wr_req;
  logic             grant_rd;
  logic             grant_wr;

  sync2 #(.RESET_VAL(1'b1)) u_rxf_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (rxf_n),
    .q       (rxf_s)
  );

  sync2 #(.RESET_VAL(1'b1)) u_txe_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (txe_n),
    .q       (txe_s)
  );

  // A read needs the one-byte output buffer empty; a write needs a byte offered.
  assign rd_req   = en & ~rxf_s & ~rx_valid;
  assign wr_req   = en & ~txe_s & tx_valid;
  // Round-robin on contention: read wins unless it was granted last time.
  assign grant_rd = rd_req & (~wr_req | (last_grant == GRANT_WRITE));
  assign grant_wr = wr_req & ~grant_rd;

  // Bus sequencer: every strobe, bus enable and status output is registered here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= GRANT_WRITE;
      cyc        <= '0;
      ftdi_rd_n  <= 1'b1;
      ftdi_wr_n  <= 1'b1;
      adbus_tri  <= 1'b0;
      adbus_out  <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_ready   <= 1'b0;
      busy       <= 1'b0;
      rx_count   <= '0;
      tx_count   <= '0;
    end else begin
      tx_ready <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (grant_rd) begin
            state      <= RD_LOW;
            last_grant <= GRANT_READ;
            ftdi_rd_n  <= 1'b0;
            busy       <= 1'b1;
            cyc        <= CYC_W'(RD_LOW_CYC - 1);
          end else if (grant_wr) begin
            state      <= WR_SETUP;
            last_grant <= GRANT_WRITE;
            adbus_out  <= tx_data;
            adbus_tri  <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b1;
            cyc        <= CYC_W'(WR_SETUP_CYC - 1);
          end
        end

        RD_LOW: begin
          if (cyc == '0) begin
            state     <= RECOVER;
            ftdi_rd_n <= 1'b1;
            rx_data   <= adbus_in;
            rx_valid  <= 1'b1;
            rx_count  <= rx_count + CNT_W'(1);
            cyc       <= CYC_W'(RECOV_CYC - 1);
          end else begin
            cyc <= cyc - CYC_W'(1);
          end
        end

        WR_SETUP: begin
          if (cyc == '0) begin
            state     <= WR_LOW;
            ftdi_wr_n <= 1'b0;
            cyc       <= CYC_W'(WR_LOW_CYC - 1);
          end else begin
            cyc <= cyc - CYC_W'(1);
          end
        end

        WR_LOW: begin
          if (cyc == '0) begin
            state     <= WR_HOLD;
            ftdi_wr_n <= 1'b1;
            cyc       <= CYC_W'(WR_HOLD_CYC - 1);
          end else begin
            cyc <= cyc - CYC_W'(1);
          end
        end

        WR_HOLD: begin
          if (cyc == '0) begin
            state     <= RECOVER;
            adbus_tri <= 1'b0;
            tx_count  <= tx_count + CNT_W'(1);
            cyc       <= CYC_W'(RECOV_CYC - 1);
          end else begin
            cyc <= cyc - CYC_W'(1);
          end
        end

        RECOVER: begin
          if (cyc == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cyc <= cyc - CYC_W'(1);
          end
        end

        default: begin
          state     <= IDLE;
          ftdi_rd_n <= 1'b1;
          ftdi_wr_n <= 1'b1;
          adbus_tri <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi_fifo_arbiter.sv
// Scoreboard bench for ftdi_fifo_arbiter: stimulus pushes expected transfers,
// a negedge monitor pops them as completed reads/writes appear on the outputs.
module tb_ftdi_fifo_arbiter;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic          rxf_n = 1'b1;
  logic          txe_n = 1'b1;
  logic [7:0]    adbus_in = 8'h00;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          rx_ready = 1'b0;
  logic [7:0]    adbus_out;
  logic          adbus_tri;
  logic          ftdi_rd_n;
  logic          ftdi_wr_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          tx_ready;
  logic          busy;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;

  ftdi_fifo_arbiter #(.CNT_W(CW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (en),
    .rxf_n     (rxf_n),
    .txe_n     (txe_n),
    .adbus_in  (adbus_in),
    .adbus_out (adbus_out),
    .adbus_tri (adbus_tri),
    .ftdi_rd_n (ftdi_rd_n),
    .ftdi_wr_n (ftdi_wr_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .rx_count  (rx_count),
    .tx_count  (tx_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit            is_write;
    logic [7:0]    data;
    logic [CW-1:0] count;
  } exp_t;

  exp_t sb[$];
  int   n_compared = 0;
  int   n_mismatched = 0;
  int   n_events = 0;
  int   exp_events = 0;
  int   n_viol = 0;
  logic prev_rx_valid = 1'b0;
  logic prev_tri = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic rxf, input logic txe,
                               input logic tv, input logic [7:0] td,
                               input logic rr, input logic [7:0] ai);
    en       = e;
    rxf_n    = rxf;
    txe_n    = txe;
    tx_valid = tv;
    tx_data  = td;
    rx_ready = rr;
    adbus_in = ai;
  endtask

  task automatic pushExp(input bit w, input logic [7:0] d, input logic [CW-1:0] c);
    sb.push_back('{is_write: w, data: d, count: c});
    exp_events++;
  endtask

  task automatic waitAll(input int limit, input string name);
    int t;
    t = 0;
    while (n_events < exp_events && t < limit) begin
      tick();
      t++;
    end
    checkOutput({name, "_done"}, 32'(n_events >= exp_events), 32'd1);
  endtask

  // Monitor: invariants every cycle, and pop the scoreboard on each completed transfer.
  always @(negedge clock) begin
    exp_t e;
    if (!ftdi_rd_n && adbus_tri) n_viol++;
    if (!ftdi_rd_n && !ftdi_wr_n) n_viol++;
    if (rx_valid && !prev_rx_valid) begin
      n_events++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_read", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("grant_kind_read", 32'd0, 32'(e.is_write));
        checkOutput("rx_data", 32'(rx_data), 32'(e.data));
        checkOutput("rx_count", 32'(rx_count), 32'(e.count));
      end
    end
    if (prev_tri && !adbus_tri && reset_n) begin
      n_events++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("grant_kind_write", 32'd1, 32'(e.is_write));
        checkOutput("wr_data", 32'(adbus_out), 32'(e.data));
        checkOutput("tx_count", 32'(tx_count), 32'(e.count));
      end
    end
    prev_rx_valid = rx_valid;
    prev_tri      = adbus_tri;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int m;
    int lows;
    int busy_cnt;
    int first_tri;
    int tri_cnt;
    int rdy_cnt;
    int bad_out;
    logic [31:0] wr_mask;

    // ---- reset values
    repeat (3) tick();
    checkOutput("rst_rd_n", 32'(ftdi_rd_n), 32'd1);
    checkOutput("rst_wr_n", 32'(ftdi_wr_n), 32'd1);
    checkOutput("rst_tri", 32'(adbus_tri), 32'd0);
    checkOutput("rst_adbus_out", 32'(adbus_out), 32'd0);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
    checkOutput("rst_tx_ready", 32'(tx_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_counts", {16'(rx_count), 16'(tx_count)}, 32'd0);
    reset_n = 1'b1;
    tick();

    // ---- single read
    pushExp(1'b0, 8'hA5, 4'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hA5);
    n = 0;
    do begin
      tick();
      n++;
    end while (ftdi_rd_n && n < 20);
    checkOutput("rd_latency", 32'(n), 32'd3);
    m = 0;
    while (!ftdi_rd_n && m < 20) begin
      tick();
      m++;
    end
    checkOutput("rd_low_width", 32'(m), 32'd3);
    waitAll(20, "read1");
    lows = 0;
    repeat (30) begin
      tick();
      if (!ftdi_rd_n) lows++;
    end
    checkOutput("no_second_read", 32'(lows), 32'd0);
    checkOutput("rx_valid_held", 32'(rx_valid), 32'd1);
    checkOutput("rx_data_held", 32'(rx_data), 32'hA5);
    rxf_n = 1'b1;
    repeat (4) tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    checkOutput("rx_valid_cleared", 32'(rx_valid), 32'd0);

    // ---- single write
    pushExp(1'b1, 8'h3C, 4'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 8'hA5);
    first_tri = -1;
    tri_cnt = 0;
    rdy_cnt = 0;
    bad_out = 0;
    wr_mask = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_ready) begin
        rdy_cnt++;
        tx_valid = 1'b0;
      end
      if (adbus_tri) begin
        if (first_tri < 0) first_tri = i;
        tri_cnt++;
        if (adbus_out !== 8'h3C) bad_out++;
      end
      if (!ftdi_wr_n) begin
        if (first_tri < 0) wr_mask[31] = 1'b1;
        else wr_mask[i - first_tri] = 1'b1;
      end
    end
    checkOutput("tx_ready_pulses", 32'(rdy_cnt), 32'd1);
    checkOutput("tri_window", 32'(tri_cnt), 32'd5);
    checkOutput("adbus_out_stable", 32'(bad_out), 32'd0);
    checkOutput("wr_low_position", wr_mask, 32'b1110);
    waitAll(20, "write1");
    checkOutput("tri_released", 32'(adbus_tri), 32'd0);
    txe_n = 1'b1;
    repeat (5) tick();

    // ---- contention: expect R, W, R, W
    pushExp(1'b0, 8'h5A, 4'd2);
    pushExp(1'b1, 8'hC3, 4'd2);
    pushExp(1'b0, 8'h5A, 4'd3);
    pushExp(1'b1, 8'hC3, 4'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 8'h5A);
    waitAll(200, "contention");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 8'h5A);
    repeat (8) tick();

    // ---- enable gating, then en dropped during WR_LOW
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0, 8'h5A);
    busy_cnt = 0;
    repeat (50) begin
      tick();
      if (busy) busy_cnt++;
    end
    checkOutput("en_low_no_busy", 32'(busy_cnt), 32'd0);
    rxf_n = 1'b1;
    repeat (4) tick();
    pushExp(1'b1, 8'h96, 4'd4);
    en = 1'b1;
    n = 0;
    while (ftdi_wr_n && n < 40) begin
      tick();
      n++;
      if (tx_ready) tx_valid = 1'b0;
    end
    checkOutput("wr_low_reached", 32'(n < 40), 32'd1);
    en = 1'b0;
    waitAll(40, "en_drop_write");
    repeat (20) tick();
    checkOutput("no_grant_after_en_drop", 32'(busy), 32'd0);
    txe_n = 1'b1;

    // ---- reset during RD_LOW
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h96, 1'b0, 8'h7E);
    n = 0;
    while (ftdi_rd_n && n < 40) begin
      tick();
      n++;
    end
    checkOutput("rd_before_reset", 32'(ftdi_rd_n), 32'd0);
    tick();
    reset_n = 1'b0;
    #1;
    checkOutput("async_rd_release", 32'(ftdi_rd_n), 32'd1);
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_rx_count", 32'(rx_count), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    tick();
    pushExp(1'b0, 8'h7E, 4'd1);
    reset_n = 1'b1;
    waitAll(40, "read_after_reset");
    rxf_n = 1'b1;
    repeat (4) tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;

    // ---- counter wrap: 17 reads from reset with a 4-bit counter
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h20);
    for (int i = 0; i < 17; i++) begin
      adbus_in = 8'(32'h20 + i);
      pushExp(1'b0, adbus_in, 4'(i + 1));
      waitAll(40, "wrap_read");
    end
    rxf_n = 1'b1;
    repeat (6) tick();
    checkOutput("rx_count_wrap", 32'(rx_count), 32'd1);

    checkOutput("invariants", 32'(n_viol), 32'd0);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
